ahb_subordinate_mem: RTL and testbench

//  AHB-Lite subordinate (responder) backed by a word-addressed memory array.

---
 rtl/ahb_subordinate_mem.sv | 162 ++++++++++++++++
 tb/tb_ahb_subordinate_mem.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_subordinate_mem.sv
// AHB-Lite subordinate backed by a word-addressed memory array.
// Supports programmable wait states, byte strobes within the HSIZE lane
// window, and the two-cycle ERROR response.
module ahb_subordinate_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic [DATA_WIDTH/8-1:0] HWSTRB,
  input  logic                    HREADY,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LOG_B  = $clog2(BYTES);
  localparam int MEM_AW = $clog2(MEM_DEPTH * BYTES);
  localparam int IDX_W  = MEM_AW - LOG_B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [2:0]          size_q, size_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  accept;
  logic                  range_err, size_err, align_err, err;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic                  complete;
  logic [IDX_W-1:0]      idx;
  logic [31:0]           lane_lo, lane_hi;
  logic [BYTES-1:0]      lane_en;
  logic                  unused_inputs;

  // Burst type, protection and the SEQ/NONSEQ distinction do not affect behaviour.
  assign unused_inputs = ^{HBURST, HPROT, HTRANS[0]};

  // Address-phase acceptance and the error classification of the presented transfer.
  always_comb begin
    accept     = HSEL & HREADY & HTRANS[1] & ((state_q == ST_IDLE) || (state_q == ST_ERR2));
    range_err  = (HADDR >> MEM_AW) != '0;
    size_err   = HSIZE > 3'(LOG_B);
    align_mask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
    align_err  = (HADDR & align_mask) != '0;
    err        = range_err | size_err | align_err;
  end

  // Next-state logic; pend marks an OKAY data phase that completes once back in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        pend_d  = 1'b0;
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = HADDR[MEM_AW-1:0];
          write_d = HWRITE;
          size_d  = HSIZE;
          if (err) begin
            state_d = ST_ERR1;
          end else begin
            pend_d = 1'b1;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = 4'(WAIT_STATES - 1);
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // Data-phase decode: completion cycle, word index and the strobed byte lanes.
  always_comb begin
    complete = (state_q == ST_IDLE) && pend_q;
    idx      = addr_q[MEM_AW-1:LOG_B];
    lane_lo  = 32'(addr_q[LOG_B-1:0]);
    lane_hi  = lane_lo + (32'd1 << size_q);
    lane_en  = '0;
    for (int unsigned k = 0; k < BYTES; k++) begin
      lane_en[k] = HWSTRB[k] && (k >= lane_lo) && (k < lane_hi);
    end
  end

  // Memory array: no reset; writes commit on the completing edge unless reset aborts them.
  always_ff @(posedge HCLK) begin
    if (HRESETn && complete && write_q) begin
      for (int unsigned k = 0; k < BYTES; k++) begin
        if (lane_en[k]) begin
          mem_q[idx][8*k +: 8] <= HWDATA[8*k +: 8];
        end
      end
    end
  end

  // Outputs decoded from registered state; read data is driven only in the completing cycle,
  // so a read right behind a write to the same word sees the freshly committed value.
  always_comb begin
    HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    HRDATA    = '0;
    if (complete && !write_q) begin
      HRDATA = mem_q[idx];
    end
  end

endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// Bench for ahb_subordinate_mem: two instances (zero and two wait states), each
// tracked by a transaction-level response model checked every cycle.
module tb_ahb_subordinate_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic [3:0]  hwstrb    [2];
  logic [31:0] hrdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  ahb_subordinate_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rstn), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(3'b001), .HPROT(4'b0011),
    .HWDATA(hwdata[0]), .HWSTRB(hwstrb[0]), .HREADY(hreadyout[0]),
    .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]));

  ahb_subordinate_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut1 (
    .HCLK(clk), .HRESETn(rstn), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(3'b011), .HPROT(4'b0000),
    .HWDATA(hwdata[1]), .HWSTRB(hwstrb[1]), .HREADY(hreadyout[1]),
    .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One expected bus cycle: ready/resp levels, and whether an OKAY transfer completes in it.
  typedef struct {
    bit          rdy;
    bit          resp;
    bit          done;
    bit          wr;
    logic [31:0] a;
    logic [2:0]  sz;
  } cyc_t;

  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int WS = (g == 0) ? 0 : 2;
    logic [7:0] mm [1024];
    cyc_t       q[$];
    cyc_t       cur;
    cyc_t       ent;
    logic [31:0] ba;
    bit          err;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
      logic [9:0] b;
      b = {a[9:2], 2'b00};
      return {mm[b + 10'd3], mm[b + 10'd2], mm[b + 10'd1], mm[b]};
    endfunction

    // Advance the expected response schedule at each edge.
    always @(posedge clk) begin
      if (!rstn) begin
        q.delete();
        cur = '{rdy: 1'b1, resp: 1'b0, done: 1'b0, wr: 1'b0, a: '0, sz: '0};
      end else begin
        if (cur.done && cur.wr) begin
          for (int k = 0; k < 4; k++) begin
            ba = {cur.a[31:2], 2'b00} + 32'(k);
            if (hwstrb[g][k] && ba >= cur.a && ba < cur.a + (32'd1 << cur.sz))
              mm[ba[9:0]] = hwdata[g][8*k +: 8];
          end
        end
        if (cur.rdy && hsel[g] && htrans[g][1]) begin
          err = (haddr[g] >= 32'd1024) || (hsize[g] > 3'd2) ||
                ((haddr[g] % (32'd1 << hsize[g])) != 0);
          if (err) begin
            q.push_back('{rdy: 1'b0, resp: 1'b1, done: 1'b0, wr: 1'b0, a: '0, sz: '0});
            q.push_back('{rdy: 1'b1, resp: 1'b1, done: 1'b0, wr: 1'b0, a: '0, sz: '0});
          end else begin
            for (int w = 0; w < WS; w++)
              q.push_back('{rdy: 1'b0, resp: 1'b0, done: 1'b0, wr: 1'b0, a: '0, sz: '0});
            q.push_back('{rdy: 1'b1, resp: 1'b0, done: 1'b1, wr: hwrite[g], a: haddr[g], sz: hsize[g]});
          end
        end
        if (q.size() > 0) cur = q.pop_front();
        else cur = '{rdy: 1'b1, resp: 1'b0, done: 1'b0, wr: 1'b0, a: '0, sz: '0};
      end
    end

    // Compare DUT outputs with the model mid-cycle.
    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("hreadyout%0d", g), 32'(hreadyout[g]), 32'(cur.rdy));
        check($sformatf("hresp%0d", g), 32'(hresp[g]), 32'(cur.resp));
        check($sformatf("hrdata%0d", g), hrdata[g],
              (cur.done && !cur.wr) ? rd_word(cur.a) : 32'h0);
      end
    end
  end

  typedef struct {
    logic [1:0]  tr;
    bit          wr;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [3:0]  st;
  } beat_t;

  beat_t       sq[$];
  logic [31:0] rd_cap   [16];
  bit          rsp_cap  [16];
  int          wait_cap [16];

  localparam logic [1:0] NS = 2'b10, SQ = 2'b11, BZ = 2'b01;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010, SD = 3'b011;

  task automatic add(input logic [1:0] tr, input bit wr, input logic [31:0] a,
                     input logic [2:0] sz, input logic [31:0] wd, input logic [3:0] st);
    sq.push_back('{tr: tr, wr: wr, a: a, sz: sz, wd: wd, st: st});
  endtask

  // Pipelined manager: address of beat k overlaps the data phase of beat k-1.
  task automatic run(input int i);
    logic [31:0] pwd;
    logic [3:0]  pst;
    bit          r;
    int          budget;
    int          n;
    n   = sq.size();
    pwd = '0;
    pst = '0;
    for (int k = 0; k <= n; k++) begin
      if (k < n) begin
        hsel[i] = 1'b1; htrans[i] = sq[k].tr; hwrite[i] = sq[k].wr;
        haddr[i] = sq[k].a; hsize[i] = sq[k].sz;
      end else begin
        hsel[i] = 1'b0; htrans[i] = 2'b00; hwrite[i] = 1'b0; haddr[i] = '0; hsize[i] = '0;
      end
      hwdata[i] = pwd;
      hwstrb[i] = pst;
      budget = 0;
      if (k > 0) wait_cap[k-1] = 0;
      forever begin
        r = hreadyout[i];
        if (k > 0) begin
          rd_cap[k-1]  = hrdata[i];
          rsp_cap[k-1] = hresp[i];
        end
        @(posedge clk);
        #1;
        if (r) break;
        if (k > 0) wait_cap[k-1]++;
        budget++;
        if (budget > 20) begin
          n_tests++;
          n_fail++;
          $display("FAIL timeout%0d: hreadyout got 0 expected 1", i);
          sq.delete();
          return;
        end
      end
      if (k < n) begin
        pwd = sq[k].wr ? sq[k].wd : 32'h0;
        pst = sq[k].wr ? sq[k].st : 4'h0;
      end
    end
    hwdata[i] = '0;
    hwstrb[i] = '0;
    sq.delete();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      hsel[i] = 1'b0; haddr[i] = '0; htrans[i] = 2'b00; hwrite[i] = 1'b0;
      hsize[i] = '0; hwdata[i] = '0; hwstrb[i] = '0;
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("reset_hreadyout", 32'(hreadyout[i]), 32'h1);
      check("reset_hresp", 32'(hresp[i]), 32'h0);
      check("reset_hrdata", hrdata[i], 32'h0);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Zero-wait write then read of the same word, back to back.
    add(NS, 1, 32'h10, SW, 32'hDEADBEEF, 4'hF);
    add(NS, 0, 32'h10, SW, 32'h0, 4'h0);
    run(0);
    check("t1_rdata", rd_cap[1], 32'hDEADBEEF);
    check("t1_waits", 32'(wait_cap[0] + wait_cap[1]), 32'h0);
    check("t1_resp", 32'(rsp_cap[1]), 32'h0);

    // Byte write into a word, and a halfword write with strobes outside its lanes.
    add(NS, 1, 32'h10, SW, 32'h11223344, 4'hF);
    add(NS, 1, 32'h13, SB, 32'hAB000000, 4'b1000);
    add(NS, 0, 32'h10, SW, 32'h0, 4'h0);
    add(NS, 1, 32'h14, SW, 32'h11223344, 4'hF);
    add(NS, 1, 32'h16, SH, 32'h55669999, 4'hF);
    add(NS, 0, 32'h14, SW, 32'h0, 4'h0);
    run(0);
    check("t2_byte", rd_cap[2], 32'hAB223344);
    check("t2_half", rd_cap[5], 32'h55663344);

    // INCR4 write with a BUSY between beats 2 and 3, then read back.
    add(NS, 1, 32'h20, SW, 32'hA0000000, 4'hF);
    add(SQ, 1, 32'h24, SW, 32'hA0000001, 4'hF);
    add(BZ, 1, 32'h28, SW, 32'h0, 4'h0);
    add(SQ, 1, 32'h28, SW, 32'hA0000002, 4'hF);
    add(SQ, 1, 32'h2C, SW, 32'hA0000003, 4'hF);
    for (int w = 0; w < 4; w++) add(NS, 0, 32'h20 + 32'(4 * w), SW, 32'h0, 4'h0);
    run(0);
    check("t5_busy_wait", 32'(wait_cap[2]), 32'h0);
    check("t5_busy_resp", 32'(rsp_cap[2]), 32'h0);
    for (int w = 0; w < 4; w++) check("t5_word", rd_cap[5 + w], 32'hA0000000 + 32'(w));

    // Last valid word, out-of-range, misaligned and oversize transfers.
    add(NS, 1, 32'h3FC, SW, 32'hCAFEF00D, 4'hF);
    add(NS, 0, 32'h3FC, SW, 32'h0, 4'h0);
    add(NS, 0, 32'h400, SW, 32'h0, 4'h0);
    add(NS, 1, 32'h404, SW, 32'hFFFFFFFF, 4'hF);
    add(NS, 1, 32'h12, SW, 32'hFFFFFFFF, 4'hF);
    add(NS, 0, 32'h10, SD, 32'h0, 4'h0);
    add(NS, 0, 32'h10, SW, 32'h0, 4'h0);
    run(0);
    check("t4_lastword", rd_cap[1], 32'hCAFEF00D);
    check("t4_err_resp", 32'(rsp_cap[2]), 32'h1);
    check("t4_err_wait", 32'(wait_cap[2]), 32'h1);
    check("t4_err2_resp", 32'(rsp_cap[3]), 32'h1);
    check("t4_misalign_resp", 32'(rsp_cap[4]), 32'h1);
    check("t4_size_resp", 32'(rsp_cap[5]), 32'h1);
    check("t4_unchanged", rd_cap[6], 32'hAB223344);

    // Two wait states: write then read.
    add(NS, 1, 32'h40, SW, 32'h12345678, 4'hF);
    add(NS, 0, 32'h40, SW, 32'h0, 4'h0);
    run(1);
    check("t3_write_waits", 32'(wait_cap[0]), 32'h2);
    check("t3_read_waits", 32'(wait_cap[1]), 32'h2);
    check("t3_rdata", rd_cap[1], 32'h12345678);
    check("t3_resp", 32'(rsp_cap[1]), 32'h0);

    // Reset during a wait-state write data phase aborts the write.
    add(NS, 1, 32'h44, SW, 32'h0BADF00D, 4'hF);
    run(1);
    hsel[1] = 1'b1; htrans[1] = NS; hwrite[1] = 1'b1; haddr[1] = 32'h44; hsize[1] = SW;
    @(posedge clk);
    #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwrite[1] = 1'b0; haddr[1] = '0;
    hwdata[1] = 32'h77777777; hwstrb[1] = 4'hF;
    check("t6_in_wait", 32'(hreadyout[1]), 32'h0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    hwdata[1] = '0; hwstrb[1] = '0;
    check("t6_hreadyout", 32'(hreadyout[1]), 32'h1);
    check("t6_hresp", 32'(hresp[1]), 32'h0);
    add(NS, 0, 32'h44, SW, 32'h0, 4'h0);
    run(1);
    check("t6_unchanged", rd_cap[0], 32'h0BADF00D);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
